// File: rtl/la_split3_pkg.sv
// Shared constants for the three-way stream splitter: destination
// encodings and the width of the illegal-beat counter.
package la_split3_pkg;

  typedef enum logic [1:0] {
    DEST_A   = 2'd0,
    DEST_B   = 2'd1,
    DEST_C   = 2'd2,
    DEST_ILL = 2'd3
  } dest_e;

  localparam int ERRCNT_W = 8;

endpackage : la_split3_pkg

// File: rtl/la_split3_slot.sv
// One-entry register slice for a single output leg of la_split3.
// Holds one beat; supports pop-and-refill on the same edge so a consumer
// holding ready high sees one beat per cycle.
module la_split3_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic          valid,
  output logic [DW-1:0] data,
  input  logic          ready,
  output logic          can_accept
);

  // Slot can take a beat when empty, or when its current beat leaves this edge.
  assign can_accept = ~valid | ready;

  // Slot state and payload; a write wins over a pop so pop+write refills.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nreset) begin
      valid <= 1'b0;
      // NOTE: the payload register is reset too, because the observable
      // data output must read zero after reset, not just the valid bit.
      data  <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      data  <= wdata;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule : la_split3_slot

// File: rtl/la_split3.sv
// Three-way registered stream splitter. Each input beat is steered by its
// 2-bit destination into one of three one-entry output slots (a, b, c);
// beats tagged with the illegal destination are dropped and counted.
module la_split3
  import la_split3_pkg::*;
#(
  parameter int    DW   = 8,
  parameter string PROP = "DEFAULT"
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                in_valid,
  input  logic [1:0]          in_dest,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic                a_valid,
  output logic [DW-1:0]       a_data,
  input  logic                a_ready,
  output logic                b_valid,
  output logic [DW-1:0]       b_data,
  input  logic                b_ready,
  output logic                c_valid,
  output logic [DW-1:0]       c_data,
  input  logic                c_ready,
  output logic                err,
  output logic [ERRCNT_W-1:0] errcnt
);

  // PROP is an implementation tag only; both branches are deliberately empty.
  if (PROP == "DEFAULT") begin : g_prop_default
  end else begin : g_prop_custom
  end

  logic a_can, b_can, c_can;
  logic accept;
  logic wr_a, wr_b, wr_c, wr_ill;

  // Ready depends only on destination, slot state and consumer ready.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // in_ready unassigned and infers a latch.
    in_ready = 1'b1;
    case (in_dest)
      DEST_A:  in_ready = a_can;
      DEST_B:  in_ready = b_can;
      DEST_C:  in_ready = c_can;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign wr_a   = accept & (in_dest == DEST_A);
  assign wr_b   = accept & (in_dest == DEST_B);
  assign wr_c   = accept & (in_dest == DEST_C);
  assign wr_ill = accept & (in_dest == DEST_ILL);

  la_split3_slot #(.DW(DW)) u_slot_a (
    .clk(clk), .nreset(nreset), .wr(wr_a), .wdata(in_data),
    .valid(a_valid), .data(a_data), .ready(a_ready), .can_accept(a_can)
  );

  la_split3_slot #(.DW(DW)) u_slot_b (
    .clk(clk), .nreset(nreset), .wr(wr_b), .wdata(in_data),
    .valid(b_valid), .data(b_data), .ready(b_ready), .can_accept(b_can)
  );

  la_split3_slot #(.DW(DW)) u_slot_c (
    .clk(clk), .nreset(nreset), .wr(wr_c), .wdata(in_data),
    .valid(c_valid), .data(c_data), .ready(c_ready), .can_accept(c_can)
  );

  // Sticky error flag and saturating count of dropped illegal beats.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      err    <= 1'b0;
      errcnt <= '0;
    end else if (wr_ill) begin
      err <= 1'b1;
      if (errcnt != '1) errcnt <= errcnt + 1'b1;
    end
  end

endmodule : la_split3

// File: tb/tb_la_split3.sv
// Directed self-checking bench for la_split3.
module tb_la_split3;

  logic       clk = 1'b0;
  logic       nreset;
  logic       in_valid;
  logic [1:0] in_dest;
  logic [7:0] in_data;
  logic       in_ready;
  logic       a_valid, b_valid, c_valid;
  logic [7:0] a_data, b_data, c_data;
  logic       a_ready, b_ready, c_ready;
  logic       err;
  logic [7:0] errcnt;

  int n_checks = 0;
  int n_fail   = 0;

  la_split3 #(.DW(8), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data), .in_ready(in_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .err(err), .errcnt(errcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, " a_valid"}, 32'(a_valid), 32'd0);
    check({tag, " b_valid"}, 32'(b_valid), 32'd0);
    check({tag, " c_valid"}, 32'(c_valid), 32'd0);
  endtask

  initial begin
    nreset   = 1'b0;
    in_valid = 1'b1;
    in_dest  = 2'd0;
    in_data  = 8'h5A;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    c_ready  = 1'b0;

    // Reset held 3 cycles with a beat presented.
    for (int i = 0; i < 3; i++) begin
      step();
      check_empty("reset");
      check("reset a_data", 32'(a_data), 32'd0);
      check("reset b_data", 32'(b_data), 32'd0);
      check("reset c_data", 32'(c_data), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset errcnt", 32'(errcnt), 32'd0);
    end
    nreset = 1'b1;
    step();
    check("post-reset a_valid", 32'(a_valid), 32'd1);
    check("post-reset a_data", 32'(a_data), 32'h5A);
    in_valid = 1'b0;
    a_ready  = 1'b1;
    step();
    check("a drained", 32'(a_valid), 32'd0);

    // Streaming to b with consumer always ready.
    b_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_dest  = 2'd1;
      in_data  = 8'(i);
      #1;
      check("stream in_ready", 32'(in_ready), 32'd1);
      step();
      check("stream b_valid", 32'(b_valid), 32'd1);
      check("stream b_data", 32'(b_data), 32'(i));
      check("stream a_valid", 32'(a_valid), 32'd0);
      check("stream c_valid", 32'(c_valid), 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 32'(b_valid), 32'd0);
    b_ready = 1'b0;

    // Backpressure on c, then pop-and-refill.
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hC3;
    step();
    check("bp c_valid", 32'(c_valid), 32'd1);
    check("bp c_data", 32'(c_data), 32'hC3);
    in_data = 8'hC4;
    #1;
    check("bp in_ready stall", 32'(in_ready), 32'd0);
    step();
    check("bp c_data held", 32'(c_data), 32'hC3);
    check("bp c_valid held", 32'(c_valid), 32'd1);
    c_ready = 1'b1;
    #1;
    check("bp in_ready pop", 32'(in_ready), 32'd1);
    step();
    check("bp refill c_valid", 32'(c_valid), 32'd1);
    check("bp refill c_data", 32'(c_data), 32'hC4);
    in_valid = 1'b0;
    step();
    check("bp drained", 32'(c_valid), 32'd0);
    c_ready = 1'b0;

    // Cross-channel independence: a stalled while b and c proceed.
    in_valid = 1'b1; in_dest = 2'd0; in_data = 8'hAA;
    step();
    check("xc a_data", 32'(a_data), 32'hAA);
    a_ready = 1'b0;
    in_dest = 2'd1; in_data = 8'h11;
    #1;
    check("xc in_ready b", 32'(in_ready), 32'd1);
    step();
    check("xc b_data", 32'(b_data), 32'h11);
    check("xc a_data held 1", 32'(a_data), 32'hAA);
    in_dest = 2'd2; in_data = 8'h22;
    #1;
    check("xc in_ready c", 32'(in_ready), 32'd1);
    step();
    check("xc c_data", 32'(c_data), 32'h22);
    check("xc a_data held 2", 32'(a_data), 32'hAA);
    in_dest = 2'd0; in_data = 8'hAB;
    #1;
    check("xc in_ready a stall", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #1;
    check("xc in_ready no in_valid path", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    a_ready  = 1'b1;
    #1;
    check("xc a_valid before pop", 32'(a_valid), 32'd1);
    check("xc a_data before pop", 32'(a_data), 32'hAA);
    check("xc in_ready a", 32'(in_ready), 32'd1);
    step();
    check("xc a refill", 32'(a_data), 32'hAB);
    a_ready = 1'b0;

    // Reset mid-operation with all three slots full and stalled.
    in_valid = 1'b0;
    check("mid all full a", 32'(a_valid), 32'd1);
    check("mid all full b", 32'(b_valid), 32'd1);
    check("mid all full c", 32'(c_valid), 32'd1);
    nreset = 1'b0;
    step();
    check_empty("mid reset");
    nreset  = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_empty("after mid reset");
    end

    // Illegal destination: 300 dropped beats, counter saturates at 255.
    check("ill err before", 32'(err), 32'd0);
    a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      in_valid = 1'b1;
      in_dest  = 2'd3;
      in_data  = 8'(i);
      #1;
      if (i <= 3 || i >= 298) check("ill in_ready", 32'(in_ready), 32'd1);
      step();
      if (i <= 3 || (i >= 253 && i <= 258) || i == 300) begin
        check("ill err", 32'(err), 32'd1);
        check("ill errcnt", 32'(errcnt), (i < 255) ? 32'(i) : 32'd255);
        check_empty("ill");
      end
    end
    in_valid = 1'b0;
    step();
    check("ill errcnt stays", 32'(errcnt), 32'd255);

    // Final reset clears error state.
    nreset = 1'b0;
    step();
    check("final err", 32'(err), 32'd0);
    check("final errcnt", 32'(errcnt), 32'd0);
    nreset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_la_split3
